// File: rtl/dbf_fine_pkg.sv
// dbf_fine_pkg: widths, FSM state type and polyphase coefficient table for the fine-delay stage.
// The table holds Catmull-Rom cubic interpolation weights for 8 fractional positions.
package dbf_fine_pkg;
    localparam int INPUT_WD = 14;
    localparam int COEF_WD  = 16;
    localparam int PHASE_WD = 3;
    localparam int ADDR_WD  = 12;
    localparam int APO_WD   = 16;
    localparam int OUT_WD   = 32;
    localparam int NPHASE   = 2 ** PHASE_WD;
    localparam int DEPTH    = 2 ** ADDR_WD;
    localparam int PROD_WD  = INPUT_WD + COEF_WD;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    typedef logic signed [COEF_WD-1:0] coef_t;

    localparam coef_t COEF [NPHASE][4] = '{
        '{ 16'sd0,     16'sd32767, 16'sd0,     16'sd0    },
        '{-16'sd1568,  16'sd31584, 16'sd2976, -16'sd224  },
        '{-16'sd2304,  16'sd28416, 16'sd7424, -16'sd768  },
        '{-16'sd2400,  16'sd23840, 16'sd12768,-16'sd1440 },
        '{-16'sd2048,  16'sd18432, 16'sd18432,-16'sd2048 },
        '{-16'sd1440,  16'sd12768, 16'sd23840,-16'sd2400 },
        '{-16'sd768,   16'sd7424,  16'sd28416,-16'sd2304 },
        '{-16'sd224,   16'sd2976,  16'sd31584,-16'sd1568 }
    };

    function automatic coef_t coef_at(input logic [PHASE_WD-1:0] phase, input logic [1:0] tap);
        return COEF[phase][tap];
    endfunction
endpackage

// File: rtl/dbf_phase_lut.sv
// dbf_phase_lut: DEPTH x PHASE_WD phase table, one write port and one registered read port.
module dbf_phase_lut
    import dbf_fine_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [ADDR_WD-1:0]  waddr,
    input  logic [PHASE_WD-1:0] wdata,
    input  logic                re,
    input  logic [ADDR_WD-1:0]  raddr,
    output logic [PHASE_WD-1:0] rdata
);
    logic [PHASE_WD-1:0] mem [DEPTH];
    logic [PHASE_WD-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_comb begin
        rdata_d = re ? mem[raddr] : rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata_q <= '0;
        else     rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/dbf_fine_interp.sv
// dbf_fine_interp: per-channel fractional-delay stage, 4-tap polyphase FIR with LUT-driven phase.
// Define APOD_EN to add an apodization multiply stage (one extra cycle of latency).
module dbf_fine_interp
    import dbf_fine_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tx_en,
    input  logic                       start,
    input  logic signed [INPUT_WD-1:0] fd_din,
    input  logic                       fd_din_valid,
    input  logic [ADDR_WD-1:0]         lut_addr,
    input  logic                       lut_we,
    input  logic [PHASE_WD-1:0]        lut_wdata,
    input  logic signed [APO_WD-1:0]   apo_din,
    output logic signed [OUT_WD-1:0]   fd_dout,
    output logic                       fd_dout_valid
);
    state_e                     state_q, state_d;
    logic [ADDR_WD-1:0]         cnt_q, cnt_d;
    logic signed [INPUT_WD-1:0] tap_q [4];
    logic signed [INPUT_WD-1:0] tap_d [4];
    logic signed [PROD_WD-1:0]  prod_q [4];
    logic signed [PROD_WD-1:0]  prod_d [4];
    logic signed [OUT_WD-1:0]   sum_q, sum_d;
    logic                       v1_q, v2_q, v3_q;
    logic [PHASE_WD-1:0]        phase;
    logic                       accept;

    assign accept = (state_q == RUN) && fd_din_valid && start && !tx_en;

    dbf_phase_lut u_lut (
        .clk   (clk),
        .rst   (rst),
        .we    (lut_we && state_q == IDLE),
        .waddr (lut_addr),
        .wdata (lut_wdata),
        .re    (accept),
        .raddr (cnt_q),
        .rdata (phase)
    );

    always_comb begin
        state_d = state_q;
        if (tx_en || !start)                  state_d = IDLE;
        else if (state_q == IDLE)             state_d = RUN;
        else if (accept && cnt_q == '1)       state_d = DONE;
        cnt_d = cnt_q;
        tap_d = tap_q;
        if (accept) begin
            tap_d = '{fd_din, tap_q[0], tap_q[1], tap_q[2]};
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + ADDR_WD'(1);
        end
        // Arming always starts from an empty delay line and LUT entry 0
        if (state_d == IDLE) begin
            cnt_d = '0;
            tap_d = '{default: '0};
        end
        for (int k = 0; k < 4; k++)
            prod_d[k] = PROD_WD'(tap_q[k]) * PROD_WD'(coef_at(phase, 2'(k)));
        sum_d = v2_q ? OUT_WD'(prod_q[0]) + OUT_WD'(prod_q[1]) + OUT_WD'(prod_q[2]) + OUT_WD'(prod_q[3])
                     : sum_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tap_q   <= '{default: '0};
            prod_q  <= '{default: '0};
            sum_q   <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tap_q   <= tap_d;
            prod_q  <= prod_d;
            sum_q   <= sum_d;
            v1_q    <= accept;
            v2_q    <= v1_q;
            v3_q    <= v2_q;
        end
    end

`ifdef APOD_EN
    logic signed [OUT_WD-1:0] out_q, out_d;
    logic                     v4_q;

    always_comb begin
        out_d = v3_q ? OUT_WD'((OUT_WD+APO_WD)'(sum_q) * (OUT_WD+APO_WD)'(apo_din) >>> (APO_WD-1)) : out_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
            v4_q  <= 1'b0;
        end else begin
            out_q <= out_d;
            v4_q  <= v3_q;
        end
    end

    assign fd_dout       = out_q;
    assign fd_dout_valid = v4_q;
`else
    logic unused_apo;
    assign unused_apo    = ^apo_din;
    assign fd_dout       = sum_q;
    assign fd_dout_valid = v3_q;
`endif
endmodule
